cbus_mem_responder: RTL and testbench



---
 rtl/cbus_pkg.sv | 22 ++
 rtl/cbus_resp_pkg.sv | 10 +
 rtl/cbus_mem_array.sv | 18 +
 rtl/cbus_mem_responder.sv | 67 ++++++
 tb/tb_cbus_mem_responder.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/cbus_pkg.sv
// cbus_pkg: cache bus request/response types and burst length encodings.
package cbus_pkg;
  localparam logic [3:0] MLEN1  = 4'd0;
  localparam logic [3:0] MLEN2  = 4'd1;
  localparam logic [3:0] MLEN4  = 4'd3;
  localparam logic [3:0] MLEN8  = 4'd7;
  localparam logic [3:0] MLEN16 = 4'd15;
  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;
  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;
endpackage

// File: rtl/cbus_resp_pkg.sv
// cbus_resp_pkg: responder FSM states, beat width and byte-strobe merge helper.
package cbus_resp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;
  localparam int BEAT_W = 4;
  function automatic logic [31:0] merge_strobe(input logic [31:0] old, input logic [31:0] wdata, input logic [3:0] strobe);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k+:8] = strobe[k] ? wdata[8*k+:8] : old[8*k+:8];
    return r;
  endfunction
endpackage

// File: rtl/cbus_mem_array.sv
// cbus_mem_array: word array with asynchronous read and byte-strobed synchronous write.
module cbus_mem_array
  import cbus_resp_pkg::*;
#(
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [MEM_AW-1:0] addr,
  input  logic [3:0]        strobe,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);
  logic [31:0] mem [2**MEM_AW];
  assign rdata = mem[addr];
  always_ff @(posedge clk)
    if (we) mem[addr] <= merge_strobe(mem[addr], wdata, strobe);
endmodule

// File: rtl/cbus_mem_responder.sv
// cbus_mem_responder: cbus memory slave answering burst reads/writes beat by beat.
module cbus_mem_responder
  import cbus_pkg::*;
  import cbus_resp_pkg::*;
#(
  parameter int MEM_AW  = 12,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp,
  output logic       err
);
  localparam int LW = LATENCY > 1 ? $clog2(LATENCY) : 1;
  state_t state, nxt;
  logic [MEM_AW-1:0] base, idx;
  logic [BEAT_W-1:0] len, beat;
  logic [LW-1:0] cnt;
  logic is_wr, last, we, viol;
  logic [31:0] rdata;
  logic unused;
  assign unused = ^{creq.size, creq.addr};
  assign idx  = base + MEM_AW'(beat);
  assign last = state == BURST && beat == len;
  assign viol = state != IDLE && !creq.valid;
  // Gating on valid keeps an aborted beat out of memory; reset forces state to IDLE so no commit.
  assign we   = state == BURST && is_wr && creq.valid;
  always_comb begin
    nxt = state == IDLE ? (creq.valid ? (LATENCY == 0 ? BURST : WAIT) : IDLE)
        : !creq.valid   ? IDLE
        : state == WAIT ? (cnt == LW'(LATENCY - 1) ? BURST : WAIT)
        : last          ? IDLE : BURST;
    cresp       = '0;
    cresp.ready = state == BURST;
    cresp.last  = last;
    cresp.data  = (state == BURST && !is_wr) ? rdata : 32'd0;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      base  <= '0;
      len   <= '0;
      is_wr <= 1'b0;
      beat  <= '0;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= nxt;
      err   <= err | viol;
      cnt   <= state == WAIT ? cnt + 1'b1 : '0;
      beat  <= (state == BURST && nxt == BURST) ? beat + 1'b1 : '0;
      if (state == IDLE && creq.valid) begin
        base  <= creq.addr[MEM_AW+1:2];
        len   <= creq.len;
        is_wr <= creq.is_write;
      end
    end
  cbus_mem_array #(.MEM_AW(MEM_AW)) u_mem (
    .clk   (clk),
    .we    (we),
    .addr  (idx),
    .strobe(creq.strobe),
    .wdata (creq.data),
    .rdata (rdata)
  );
endmodule

// File: tb/tb_cbus_mem_responder.sv
// tb_cbus_mem_responder: directed checks of burst timing, strobes, wrap, abort and reset.
module tb_cbus_mem_responder;
  import cbus_pkg::*;
  localparam int LATENCY = 2;
  logic clk, resetn, err;
  cbus_req_t creq;
  cbus_resp_t cresp;
  logic [31:0] wdat [16];
  logic [31:0] exp_d [16];
  int checks = 0, errors = 0;
  cbus_mem_responder #(.MEM_AW(12), .LATENCY(LATENCY)) dut (
    .clk   (clk),
    .resetn(resetn),
    .creq  (creq),
    .cresp (cresp),
    .err   (err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, got, want);
    end
  endtask
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [3:0] len, input logic [3:0] strb);
    int cyc, beat;
    bit done;
    creq.valid = 1'b1; creq.is_write = wr; creq.addr = addr; creq.len = len;
    creq.strobe = strb; creq.size = 3'd2; creq.data = wdat[0];
    cyc = 0; beat = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (cresp.ready) begin
        if (beat == 0) check("lat", 32'(cyc), 32'(LATENCY + 1));
        check("last", 32'(cresp.last), 32'(beat == int'(len)));
        check(wr ? "wdata0" : "rdata", cresp.data, wr ? 32'd0 : exp_d[beat]);
        done = beat == int'(len);
        beat++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (beat < 16) creq.data = wdat[beat];
    end
    if (!done) check("timeout", 32'd0, 32'd1);
    creq.valid = 1'b0;
  endtask
  initial begin
    int cyc, seen;
    resetn = 1'b0;
    creq = '0;
    tick(3);
    @(negedge clk);
    check("rst_ready", 32'(cresp.ready), 32'd0);
    check("rst_last", 32'(cresp.last), 32'd0);
    check("rst_data", cresp.data, 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    tick(1);
    // read burst over preloaded words 0x40..0x43
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hA0 + 32'(i); exp_d[i] = 32'hA0 + 32'(i); end
    xfer(1'b1, 32'h100, MLEN4, 4'hF);
    tick(1);
    xfer(1'b0, 32'h100, MLEN4, 4'hF);
    tick(1);
    // strobed single-beat write
    wdat[0] = 32'h11223344;
    xfer(1'b1, 32'h200, MLEN1, 4'hF);
    tick(1);
    wdat[0] = 32'hAABBCCDD;
    xfer(1'b1, 32'h200, MLEN1, 4'b0101);
    tick(1);
    exp_d[0] = 32'h11BB33DD;
    xfer(1'b0, 32'h200, MLEN1, 4'hF);
    tick(1);
    // wrap at top of array: words 4094, 4095, 0, 1
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'hC0DE0000 + 32'(i); exp_d[i] = wdat[i]; end
    xfer(1'b1, 32'h3FF8, MLEN4, 4'hF);
    tick(1);
    xfer(1'b0, 32'h3FF8, MLEN4, 4'hF);
    tick(1);
    exp_d[0] = 32'hC0DE0002; exp_d[1] = 32'hC0DE0003;
    xfer(1'b0, 32'h0, MLEN2, 4'hF);
    // back-to-back: one idle cycle with valid low
    @(negedge clk);
    check("b2b_idle_ready", 32'(cresp.ready), 32'd0);
    @(posedge clk);
    #1;
    exp_d[0] = 32'hA0; exp_d[1] = 32'hA1;
    xfer(1'b0, 32'h100, MLEN2, 4'hF);
    check("b2b_err", 32'(err), 32'd0);
    tick(1);
    // reset in the middle of an 8-beat write
    for (int i = 0; i < 8; i++) wdat[i] = 32'd0;
    xfer(1'b1, 32'h300, MLEN8, 4'hF);
    tick(1);
    creq.valid = 1'b1; creq.is_write = 1'b1; creq.addr = 32'h300; creq.len = MLEN8;
    creq.strobe = 4'hF; creq.data = 32'h50;
    cyc = 0;
    @(negedge clk);
    while (!cresp.ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_start", 32'(cresp.ready), 32'd1);
    @(posedge clk); #1; creq.data = 32'h51;
    @(posedge clk); #1; creq.data = 32'h52;
    @(negedge clk);
    check("rst_mid_pre", 32'(cresp.ready), 32'd1);
    resetn = 1'b0;
    #1;
    check("rst_mid_ready", 32'(cresp.ready), 32'd0);
    check("rst_mid_last", 32'(cresp.last), 32'd0);
    creq.valid = 1'b0;
    tick(2);
    resetn = 1'b1;
    tick(2);
    @(negedge clk);
    check("rst_mid_idle", 32'(cresp.ready), 32'd0);
    check("rst_mid_err", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) exp_d[i] = 32'd0;
    exp_d[0] = 32'h50; exp_d[1] = 32'h51;
    xfer(1'b0, 32'h300, MLEN8, 4'hF);
    tick(1);
    // drop valid during WAIT
    creq.valid = 1'b1; creq.is_write = 1'b0; creq.addr = 32'h100; creq.len = MLEN4;
    tick(2);
    creq.valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cresp.ready) seen++;
    end
    check("viol_no_ready", 32'(seen), 32'd0);
    check("viol_err", 32'(err), 32'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) exp_d[i] = 32'hA0 + 32'(i);
    xfer(1'b0, 32'h100, MLEN4, 4'hF);
    check("viol_err_held", 32'(err), 32'd1);
    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
